stitch_pipeline_drain: RTL and testbench

- Credit-based output collector for a stitched, fixed-latency, non-stallable pipeline. The pipeline's stage registers have no enable and no reset.
- Tracks which issue slots carry valid data, captures pipeline results into a FIFO, and presents them downstream with valid/ready.
- Throttles upstream issue so an arriving result always has a FIFO slot. Sits between the pipeline's `out` port and the downstream consumer.

---
 rtl/stitch_pipeline_drain.sv | 64 ++++++
 tb/tb_stitch_pipeline_drain.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/stitch_pipeline_drain.sv
// stitch_pipeline_drain: credit-throttled output FIFO for a fixed-latency, non-stallable pipeline.
// Valid bits shadow the pipeline stages so only genuine results are captured.
module stitch_pipeline_drain #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         pipe_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy,
    output logic [$clog2(DEPTH+1)-1:0]    credits,
    output logic                          overflow_err
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [LATENCY-1:0]    v;
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  issue, arrival, pop, full, write;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = (credits != '0) & ~rst;
    assign out_valid = occupancy != '0;
    assign out_data  = mem[rd_ptr];
    assign issue     = in_valid & in_ready;
    assign arrival   = v[LATENCY-1];
    assign pop       = out_valid & out_ready;
    assign full      = occupancy == CW'(DEPTH);
    // A full FIFO still accepts an arrival when the head leaves in the same cycle.
    assign write     = arrival & (~full | pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            v            <= '0;
            credits      <= CW'(DEPTH);
            occupancy    <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            overflow_err <= 1'b0;
        end else begin
            v[0] <= issue;
            for (int i = 1; i < LATENCY; i++) v[i] <= v[i-1];
            credits   <= credits + CW'(pop) - CW'(issue);
            occupancy <= occupancy + CW'(write) - CW'(pop);
            if (write) wr_ptr <= nxt(wr_ptr);
            if (pop) rd_ptr <= nxt(rd_ptr);
            if (arrival & full & ~pop) overflow_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (write) mem[wr_ptr] <= pipe_out;
    end
endmodule

// File: tb/tb_stitch_pipeline_drain.sv
// tb_stitch_pipeline_drain: table-driven check of the drain collector behind a modelled 2-stage pipeline,
// plus a DEPTH=3 wrap-around instance and hand sequences for reset and overflow.
module tb_stitch_pipeline_drain;
    logic        clk = 0;
    logic        rst = 1;
    logic        iv = 0, ordy = 0, ovr_en = 0;
    logic [31:0] pin = 0, ovr = 0, s0, s1, pipe_out;
    logic        ir, ov, err;
    logic [31:0] od;
    logic [2:0]  occ, cr;
    logic        iv3 = 0, or3 = 0, ir3, ov3, err3;
    logic [31:0] pin3 = 0, t0, t1, od3;
    logic [1:0]  occ3, cr3;
    int          n_pass = 0, n_total = 0;
    localparam logic [31:0] BAD = 32'hBAD0_0BAD;

    always #5 clk = ~clk;

    // Stand-in for the unreset, non-stallable pipeline: two bare stage registers.
    always_ff @(posedge clk) begin
        s0 <= pin;
        s1 <= s0;
        t0 <= pin3;
        t1 <= t0;
    end
    assign pipe_out = ovr_en ? ovr : s1;

    stitch_pipeline_drain #(.DATA_WIDTH(32), .LATENCY(2), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .pipe_out(pipe_out),
        .out_valid(ov), .out_ready(ordy), .out_data(od), .occupancy(occ),
        .credits(cr), .overflow_err(err)
    );

    stitch_pipeline_drain #(.DATA_WIDTH(32), .LATENCY(2), .DEPTH(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .pipe_out(t1),
        .out_valid(ov3), .out_ready(or3), .out_data(od3), .occupancy(occ3),
        .credits(cr3), .overflow_err(err3)
    );

    typedef struct {
        logic        iv, ordy;
        logic [31:0] pin;
        logic        ir, ov;
        logic [31:0] data;
        int          occ, cr;
    } vec_t;

    vec_t tbl [31];

    function automatic vec_t mk(input logic a, b, input logic [31:0] p, input logic r, o,
                                input logic [31:0] d, input int oc, c);
        vec_t x;
        x.iv = a; x.ordy = b; x.pin = p; x.ir = r; x.ov = o; x.data = d; x.occ = oc; x.cr = c;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic a, b, input logic [31:0] p);
        iv = a;
        ordy = b;
        pin = p;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int issued, got;
        logic [1:0] fl;
        logic fi, fo;
        // Single transaction, then full throughput, then backpressure.
        tbl[0]  = mk(1, 0, 32'h7, 1, 0, 0, 0, 4);
        tbl[1]  = mk(0, 0, BAD, 1, 0, 0, 0, 3);
        tbl[2]  = mk(0, 0, BAD, 1, 0, 0, 0, 3);
        tbl[3]  = mk(0, 1, BAD, 1, 1, 32'h7, 1, 3);
        tbl[4]  = mk(0, 0, BAD, 1, 0, 0, 0, 4);
        tbl[5]  = mk(1, 1, 32'h0, 1, 0, 0, 0, 4);
        tbl[6]  = mk(1, 1, 32'h1, 1, 0, 0, 0, 3);
        tbl[7]  = mk(1, 1, 32'h2, 1, 0, 0, 0, 2);
        tbl[8]  = mk(1, 1, 32'h3, 1, 1, 32'h0, 1, 1);
        tbl[9]  = mk(1, 1, 32'h4, 1, 1, 32'h1, 1, 1);
        tbl[10] = mk(1, 1, 32'h5, 1, 1, 32'h2, 1, 1);
        tbl[11] = mk(0, 1, BAD, 1, 1, 32'h3, 1, 1);
        tbl[12] = mk(0, 1, BAD, 1, 1, 32'h4, 1, 2);
        tbl[13] = mk(0, 1, BAD, 1, 1, 32'h5, 1, 3);
        tbl[14] = mk(0, 0, BAD, 1, 0, 0, 0, 4);
        tbl[15] = mk(1, 0, 32'h10, 1, 0, 0, 0, 4);
        tbl[16] = mk(1, 0, 32'h11, 1, 0, 0, 0, 3);
        tbl[17] = mk(1, 0, 32'h12, 1, 0, 0, 0, 2);
        tbl[18] = mk(1, 0, 32'h13, 1, 1, 32'h10, 1, 1);
        tbl[19] = mk(1, 0, BAD, 0, 1, 32'h10, 2, 0);
        tbl[20] = mk(1, 0, BAD, 0, 1, 32'h10, 3, 0);
        tbl[21] = mk(1, 0, BAD, 0, 1, 32'h10, 4, 0);
        tbl[22] = mk(1, 1, BAD, 0, 1, 32'h10, 4, 0);
        tbl[23] = mk(1, 0, 32'h14, 1, 1, 32'h11, 3, 1);
        tbl[24] = mk(1, 0, BAD, 0, 1, 32'h11, 3, 0);
        tbl[25] = mk(0, 0, BAD, 0, 1, 32'h11, 3, 0);
        tbl[26] = mk(0, 1, BAD, 0, 1, 32'h11, 4, 0);
        tbl[27] = mk(0, 1, BAD, 1, 1, 32'h12, 3, 1);
        tbl[28] = mk(0, 1, BAD, 1, 1, 32'h13, 2, 2);
        tbl[29] = mk(0, 1, BAD, 1, 1, 32'h14, 1, 3);
        tbl[30] = mk(0, 0, BAD, 1, 0, 0, 0, 4);

        rst = 1;
        drive(1, 0, BAD);
        tick();
        chk("reset in_ready", ir, 0);
        chk("reset out_valid", ov, 0);
        chk("reset occupancy", occ, 0);
        chk("reset credits", cr, 4);
        chk("reset overflow", err, 0);
        chk("reset credits d3", cr3, 3);
        rst = 0;

        for (int i = 0; i < 31; i++) begin
            drive(tbl[i].iv, tbl[i].ordy, tbl[i].pin);
            chk($sformatf("row%0d in_ready", i), ir, tbl[i].ir);
            chk($sformatf("row%0d out_valid", i), ov, tbl[i].ov);
            chk($sformatf("row%0d occupancy", i), occ, tbl[i].occ);
            chk($sformatf("row%0d credits", i), cr, tbl[i].cr);
            chk($sformatf("row%0d overflow", i), err, 0);
            if (tbl[i].ov) chk($sformatf("row%0d out_data", i), od, tbl[i].data);
            tick();
        end

        // Reset with two results in flight and two in the FIFO; stale pipeline data must not land.
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 32'h40 + k);
            tick();
        end
        drive(0, 0, BAD);
        rst = 1;
        #1;
        chk("midrst occupancy before", occ, 2);
        chk("midrst in_ready during rst", ir, 0);
        tick();
        rst = 0;
        ovr_en = 1;
        ovr = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) ovr_en = 0;
            drive(0, 0, BAD);
            chk($sformatf("midrst%0d out_valid", k), ov, 0);
            chk($sformatf("midrst%0d occupancy", k), occ, 0);
            chk($sformatf("midrst%0d credits", k), cr, 4);
            tick();
        end
        chk("midrst settled out_valid", ov, 0);

        // Wrap-around on the DEPTH=3 instance with alternating out_ready.
        issued = 0;
        got = 0;
        fl = 2'b00;
        for (int c = 0; c < 200 && got < 10; c++) begin
            iv3 = issued < 10;
            or3 = c[0];
            pin3 = 32'hA0 + issued;
            #1;
            fi = iv3 & ir3;
            fo = ov3 & or3;
            if (fo) begin
                chk($sformatf("wrap data%0d", got), od3, 32'hA0 + got);
                got++;
            end
            chk("wrap invariant", int'(cr3) + int'(occ3) + int'(fl[0]) + int'(fl[1]), 3);
            @(posedge clk);
            fl = {fl[0], fi};
            issued += int'(fi);
            #1;
        end
        iv3 = 0;
        or3 = 0;
        chk("wrap count", got, 10);
        chk("wrap overflow", err3, 0);

        // Overflow injection: fake an arrival into a full FIFO with no pop.
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 32'h30 + k);
            tick();
        end
        drive(0, 0, BAD);
        tick();
        tick();
        chk("ovf full occupancy", occ, 4);
        chk("ovf clean before", err, 0);
        force dut.v = 2'b10;
        @(posedge clk);
        #1;
        release dut.v;
        chk("ovf set", err, 1);
        chk("ovf occupancy kept", occ, 4);
        chk("ovf head kept", od, 32'h30);
        tick();
        chk("ovf sticky", err, 1);
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, BAD);
            chk($sformatf("ovf contents%0d", k), od, 32'h30 + k);
            tick();
        end
        drive(0, 0, BAD);
        chk("ovf drained", ov, 0);
        chk("ovf still sticky", err, 1);
        rst = 1;
        tick();
        rst = 0;
        #1;
        chk("ovf cleared by rst", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
